airi5c_pre_processing: RTL and testbench

AIRI5C_PRE_PROCESSING -- requirements
Module: airi5c_pre_processing

---
 rtl/airi5c_pre_processing.sv | 140 ++++++++++++++
 tb/tb_airi5c_pre_processing.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/airi5c_pre_processing.sv
// Unpacks and classifies an IEEE-754 binary32 operand; result 2 cycles after load.
// No backpressure: one operand accepted per cycle, ready pulses with each result.
module airi5c_pre_processing (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        kill,
  input  logic        load,
  input  logic [31:0] float_in,
  output logic [23:0] man,
  output logic [9:0]  Exp,
  output logic        sgn,
  output logic        zero,
  output logic        inf,
  output logic        nan,
  output logic        snan,
  output logic        qnan,
  output logic        denormal,
  output logic [9:0]  fclass,
  output logic        ready
);

  typedef struct packed {
    logic [31:0] raw;
    logic        zero;
    logic        inf;
    logic        nan;
    logic        snan;
    logic        qnan;
    logic        denormal;
    logic        normal;
    logic [4:0]  lz;
  } s1_t;

  s1_t         s1_nxt;
  s1_t         s1_dat;
  logic        s1_vld;

  logic [7:0]  in_exp;
  logic [22:0] in_frac;
  logic        exp_zero;
  logic        exp_max;
  logic        frac_zero;
  logic        lz_found;

  assign in_exp    = float_in[30:23];
  assign in_frac   = float_in[22:0];
  assign exp_zero  = (in_exp == 8'd0);
  assign exp_max   = (in_exp == 8'hFF);
  assign frac_zero = (in_frac == 23'd0);

  always_comb begin
    s1_nxt          = '0;
    s1_nxt.raw      = float_in;
    s1_nxt.zero     = exp_zero & frac_zero;
    s1_nxt.denormal = exp_zero & ~frac_zero;
    s1_nxt.normal   = ~exp_zero & ~exp_max;
    s1_nxt.inf      = exp_max & frac_zero;
    s1_nxt.nan      = exp_max & ~frac_zero;
    s1_nxt.snan     = exp_max & ~frac_zero & ~in_frac[22];
    s1_nxt.qnan     = exp_max & in_frac[22];
    // A zero fraction leaves lz at 23; it is only consumed for denormals.
    s1_nxt.lz       = 5'd23;
    lz_found        = 1'b0;
    for (int i = 22; i >= 0; i--) begin
      if (!lz_found && in_frac[i]) begin
        s1_nxt.lz = 5'(22 - i);
        lz_found  = 1'b1;
      end
    end
  end

  logic [23:0] man_nxt;
  logic [9:0]  exp_nxt;
  logic [9:0]  fclass_nxt;
  logic        s1_sgn;
  logic [5:0]  shamt;

  assign s1_sgn = s1_dat.raw[31];
  assign shamt  = {1'b0, s1_dat.lz} + 6'd1;

  always_comb begin
    man_nxt = {1'b1, s1_dat.raw[22:0]};
    exp_nxt = 10'h080;
    if (s1_dat.zero) begin
      man_nxt = 24'd0;
      exp_nxt = 10'h381;
    end else if (s1_dat.denormal) begin
      man_nxt = {1'b0, s1_dat.raw[22:0]} << shamt;
      exp_nxt = 10'h381 - {5'd0, s1_dat.lz};
    end else if (s1_dat.normal) begin
      exp_nxt = {2'b00, s1_dat.raw[30:23]} - 10'd127;
    end
  end

  assign fclass_nxt = {s1_dat.qnan,
                       s1_dat.snan,
                       s1_dat.inf      & ~s1_sgn,
                       s1_dat.normal   & ~s1_sgn,
                       s1_dat.denormal & ~s1_sgn,
                       s1_dat.zero     & ~s1_sgn,
                       s1_dat.zero     &  s1_sgn,
                       s1_dat.denormal &  s1_sgn,
                       s1_dat.normal   &  s1_sgn,
                       s1_dat.inf      &  s1_sgn};

  always_ff @(posedge clk) begin
    if (!n_reset || kill) begin
      s1_vld   <= 1'b0;
      s1_dat   <= '0;
      man      <= '0;
      Exp      <= '0;
      sgn      <= 1'b0;
      zero     <= 1'b0;
      inf      <= 1'b0;
      nan      <= 1'b0;
      snan     <= 1'b0;
      qnan     <= 1'b0;
      denormal <= 1'b0;
      fclass   <= '0;
      ready    <= 1'b0;
    end else begin
      s1_vld <= load;
      if (load) s1_dat <= s1_nxt;
      ready  <= s1_vld;
      if (s1_vld) begin
        man      <= man_nxt;
        Exp      <= exp_nxt;
        sgn      <= s1_sgn;
        zero     <= s1_dat.zero;
        inf      <= s1_dat.inf;
        nan      <= s1_dat.nan;
        snan     <= s1_dat.snan;
        qnan     <= s1_dat.qnan;
        denormal <= s1_dat.denormal;
        fclass   <= fclass_nxt;
      end
    end
  end

endmodule

// File: tb/tb_airi5c_pre_processing.sv
// Directed-vector bench for airi5c_pre_processing with hand-computed results.
module tb_airi5c_pre_processing;

  logic        clk = 1'b0;
  logic        n_reset, kill, load;
  logic [31:0] float_in;
  logic [23:0] man;
  logic [9:0]  Exp;
  logic        sgn, zero, inf, nan, snan, qnan, denormal;
  logic [9:0]  fclass;
  logic        ready;

  int checks = 0;
  int failures = 0;

  airi5c_pre_processing dut (
    .clk(clk), .n_reset(n_reset), .kill(kill), .load(load), .float_in(float_in),
    .man(man), .Exp(Exp), .sgn(sgn), .zero(zero), .inf(inf), .nan(nan),
    .snan(snan), .qnan(qnan), .denormal(denormal), .fclass(fclass), .ready(ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_out();
    return {12'd0, man, Exp, sgn, zero, inf, nan, snan, qnan, denormal, fclass, ready};
  endfunction

  // flags ordering: {zero, inf, nan, snan, qnan, denormal}
  task automatic check_result(input string tag, input logic [23:0] e_man, input logic [9:0] e_exp,
                              input logic e_sgn, input logic [5:0] e_flags, input logic [9:0] e_fclass);
    check({tag, ".ready"}, 64'(ready), 64'd1);
    check({tag, ".man"}, 64'(man), 64'(e_man));
    check({tag, ".exp"}, 64'(Exp), 64'(e_exp));
    check({tag, ".sgn"}, 64'(sgn), 64'(e_sgn));
    check({tag, ".flags"}, 64'({zero, inf, nan, snan, qnan, denormal}), 64'(e_flags));
    check({tag, ".fclass"}, 64'(fclass), 64'(e_fclass));
  endtask

  task automatic run_one(input string tag, input logic [31:0] v, input logic [23:0] e_man,
                         input logic [9:0] e_exp, input logic e_sgn, input logic [5:0] e_flags,
                         input logic [9:0] e_fclass);
    load = 1'b1; float_in = v;
    tick();
    load = 1'b0; float_in = 32'hDEADBEEF;
    check({tag, ".ready_early"}, 64'(ready), 64'd0);
    tick();
    check_result(tag, e_man, e_exp, e_sgn, e_flags, e_fclass);
    tick();
    check({tag, ".ready_pulse"}, 64'(ready), 64'd0);
  endtask

  initial begin
    n_reset = 1'b0; kill = 1'b0; load = 1'b1; float_in = 32'h3F800000;
    tick(); tick();
    check("reset_state", all_out(), 64'd0);
    n_reset = 1'b1; load = 1'b0;
    tick();
    check("reset_load_dropped", 64'(ready), 64'd0);

    run_one("one",      32'h3F800000, 24'h800000, 10'h000, 1'b0, 6'b000000, 10'h040);
    run_one("den_min",  32'h00000001, 24'h800000, 10'h36B, 1'b0, 6'b000001, 10'h020);
    run_one("den_max",  32'h007FFFFF, 24'hFFFFFE, 10'h381, 1'b0, 6'b000001, 10'h020);
    run_one("neg_den",  32'h80400000, 24'h800000, 10'h381, 1'b1, 6'b000001, 10'h004);
    run_one("neg_zero", 32'h80000000, 24'h000000, 10'h381, 1'b1, 6'b100000, 10'h008);
    run_one("pos_zero", 32'h00000000, 24'h000000, 10'h381, 1'b0, 6'b100000, 10'h010);
    run_one("neg_inf",  32'hFF800000, 24'h800000, 10'h080, 1'b1, 6'b010000, 10'h001);
    run_one("pos_inf",  32'h7F800000, 24'h800000, 10'h080, 1'b0, 6'b010000, 10'h080);
    run_one("neg_pi",   32'hC0490FDB, 24'hC90FDB, 10'h001, 1'b1, 6'b000000, 10'h002);
    run_one("max_norm", 32'h7F7FFFFF, 24'hFFFFFF, 10'h07F, 1'b0, 6'b000000, 10'h040);
    run_one("min_norm", 32'h00800000, 24'h800000, 10'h382, 1'b0, 6'b000000, 10'h040);

    // Back-to-back NaNs: ready stays high two cycles.
    load = 1'b1; float_in = 32'h7F800001;
    tick();
    float_in = 32'h7FC00000;
    tick();
    load = 1'b0;
    check_result("snan", 24'h800001, 10'h080, 1'b0, 6'b001100, 10'h100);
    tick();
    check_result("qnan", 24'hC00000, 10'h080, 1'b0, 6'b001010, 10'h200);
    tick();
    check("nan_ready_drop", 64'(ready), 64'd0);
    check("hold_man", 64'(man), 64'h00C00000);

    // Reset without a clock edge changes nothing.
    n_reset = 1'b0;
    #2;
    check("async_reset_ignored", 64'(fclass), 64'h200);
    n_reset = 1'b1;
    tick();

    // Kill after load, with a concurrent load that must be discarded.
    load = 1'b1; float_in = 32'h3F800000;
    tick();
    kill = 1'b1; float_in = 32'h40000000;
    tick();
    kill = 1'b0; load = 1'b0;
    check("kill_clear", all_out(), 64'd0);
    tick();
    check("kill_no_ready1", 64'(ready), 64'd0);
    tick();
    check("kill_no_ready2", all_out(), 64'd0);

    // Load immediately after a kill cycle is processed normally.
    kill = 1'b1;
    tick();
    kill = 1'b0;
    run_one("after_kill", 32'h40000000, 24'h800000, 10'h001, 1'b0, 6'b000000, 10'h040);

    // Reset mid-operation drops the in-flight operand.
    load = 1'b1; float_in = 32'hBF800000;
    tick();
    n_reset = 1'b0; load = 1'b0;
    tick();
    n_reset = 1'b1;
    check("midop_reset", all_out(), 64'd0);
    tick();
    check("midop_no_ready1", 64'(ready), 64'd0);
    tick();
    check("midop_no_ready2", all_out(), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
